// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with built-in clear sequencer.
//
// Storage is distributed RAM with no reset. After reset, or on a clr
// request, a sweep writes zero to every entry, one entry per clock. While
// the sweep runs, ready is low, writes are ignored and every read port
// returns zero.
//
// Ports:
//   clock    in   rising-edge system clock
//   n_rst    in   asynchronous active-low reset (state, sweep counter, ready)
//   clr      in   synchronous request to re-run the clear sweep
//   r_addr   in   NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   r_data   out  NUM_RD packed read data, port i at [i*DATA_W +: DATA_W]
//   w0_addr/w0_data/w0_we  in  write port 0
//   w1_addr/w1_data/w1_we  in  write port 1 (wins on an address collision)
//   ready    out  storage valid and writes accepted
//
// Optional macro REG_FILE_BYPASS_EN: when defined, a read port whose address
// matches an enabled write port returns that write data in the same cycle
// (w1 before w0). When undefined, reads return stored contents only.

module reg_file_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) (
  input  logic                       clock,
  input  logic                       n_rst,
  input  logic                       clr,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
  output logic [NUM_RD*DATA_W-1:0]   r_data,
  input  logic [ADDR_W-1:0]          w0_addr,
  input  logic [DATA_W-1:0]          w0_data,
  input  logic                       w0_we,
  input  logic [ADDR_W-1:0]          w1_addr,
  input  logic [DATA_W-1:0]          w1_data,
  input  logic                       w1_we,
  output logic                       ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Sequencer: state, sweep counter and registered ready.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      if (clr) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (clr) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end
  end

  // Storage. Writes sampled on the clr edge in RUN still commit because
  // state is still RUN on that edge. While held in reset, cnt stays at 0 so
  // only mem[0] is rewritten with zero, which the sweep does anyway and
  // which no read port can observe before the sweep completes.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (w0_we && !(w1_we && (w1_addr == w0_addr))) begin
        mem[w0_addr] <= w0_data;
      end
      if (w1_we) begin
        mem[w1_addr] <= w1_data;
      end
    end
  end

  // Combinational read ports, forced to zero until the storage is valid.
  always_comb begin
    r_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (ready) begin
        r_data[i*DATA_W +: DATA_W] = mem[r_addr[i*ADDR_W +: ADDR_W]];
`ifdef REG_FILE_BYPASS_EN
        if (w1_we && (w1_addr == r_addr[i*ADDR_W +: ADDR_W])) begin
          r_data[i*DATA_W +: DATA_W] = w1_data;
        end else if (w0_we && (w0_addr == r_addr[i*ADDR_W +: ADDR_W])) begin
          r_data[i*DATA_W +: DATA_W] = w0_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks of reg_file_mp against a
// behavioural model (plain array plus sweep countdown), compared every
// cycle on the falling clock edge, plus literal expectations for the
// directed scenarios.

module tb_reg_file_mp;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int DEPTH = 16;

  logic              clock;
  logic              n_rst;
  logic              clr;
  logic [NR*AW-1:0]  r_addr;
  logic [NR*DW-1:0]  r_data;
  logic [AW-1:0]     w0_addr;
  logic [DW-1:0]     w0_data;
  logic              w0_we;
  logic [AW-1:0]     w1_addr;
  logic [DW-1:0]     w1_data;
  logic              w1_we;
  logic              ready;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clock  (clock),
    .n_rst  (n_rst),
    .clr    (clr),
    .r_addr (r_addr),
    .r_data (r_data),
    .w0_addr(w0_addr),
    .w0_data(w0_data),
    .w0_we  (w0_we),
    .w1_addr(w1_addr),
    .w1_data(w1_data),
    .w1_we  (w1_we),
    .ready  (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: contents array, ready flag, edges left in the sweep.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ready = 1'b0;
  int            m_left  = DEPTH;

  always @(posedge clock) begin
    if (!n_rst) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
    end else if (!m_ready) begin
      if (clr) begin
        m_left = DEPTH;
      end else begin
        m_left--;
        if (m_left == 0) begin
          for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
          m_ready = 1'b1;
        end
      end
    end else begin
      if (w0_we) m_mem[w0_addr] = w0_data;
      if (w1_we) m_mem[w1_addr] = w1_data;  // applied last: w1 wins
      if (clr) begin
        m_ready = 1'b0;
        m_left  = DEPTH;
      end
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit rdy);
    logic [DW-1:0] v;
    if (!rdy) return '0;
    v = m_mem[a];
`ifdef REG_FILE_BYPASS_EN
    if (w1_we && w1_addr == a) v = w1_data;
    else if (w0_we && w0_addr == a) v = w0_data;
`endif
    return v;
  endfunction

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clock) begin
    bit er;
    er = n_rst && m_ready;
    check("ready", {31'b0, ready}, {31'b0, er});
    for (int i = 0; i < NR; i++) begin
      check($sformatf("r_data%0d", i), {16'b0, r_data[i*DW +: DW]},
            {16'b0, model_read(r_addr[i*AW +: AW], er)});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_writes();
    w0_we = 1'b0;
    w1_we = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    r_addr = {a1, a0};
  endtask

  // Wait out a sweep whose first edge is the next posedge: ready low after
  // 15 edges, high after the 16th.
  task automatic sweep_wait(input string tag);
    for (int k = 0; k < DEPTH - 1; k++) begin
      tick();
      check({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
    end
    tick();
    check({tag, "_ready_high"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] rdw_exp;
    n_rst = 1'b0;
    clr = 1'b0;
    r_addr = '0;
    w0_addr = '0; w0_data = '0; w0_we = 1'b0;
    w1_addr = '0; w1_data = '0; w1_we = 1'b0;
    #1;
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_rdata", r_data, 32'd0);
    repeat (2) @(negedge clock);
    n_rst = 1'b1;

    // Reset sweep
    sweep_wait("sweep");
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      #2;
      check("sweep_zero", r_data, 32'd0);
      tick();
    end

    // Basic write
    w0_addr = 4'd3; w0_data = 16'h1234; w0_we = 1'b1;
    w1_addr = 4'd5; w1_data = 16'hABCD; w1_we = 1'b1;
    tick();
    idle_writes();
    set_rd(4'd3, 4'd5);
    #2;
    check("basic_w0", {16'b0, r_data[15:0]}, 32'h1234);
    check("basic_w1", {16'b0, r_data[31:16]}, 32'hABCD);
    set_rd(4'd4, 4'd6);
    #2;
    check("basic_other", r_data, 32'd0);
    tick();

    // Collision: w1 wins
    w0_addr = 4'd8; w0_data = 16'h8000; w0_we = 1'b1;
    w1_addr = 4'd8; w1_data = 16'h0008; w1_we = 1'b1;
    tick();
    idle_writes();
    set_rd(4'd8, 4'd8);
    #2;
    check("collide", {16'b0, r_data[15:0]}, 32'h0008);
    tick();

    // Read during write
    w0_addr = 4'd8; w0_data = 16'hFFFF; w0_we = 1'b1;
`ifdef REG_FILE_BYPASS_EN
    rdw_exp = 16'hFFFF;
`else
    rdw_exp = 16'h0008;
`endif
    #2;
    check("rdw_before", {16'b0, r_data[15:0]}, {16'b0, rdw_exp});
    tick();
    idle_writes();
    #2;
    check("rdw_after", {16'b0, r_data[15:0]}, 32'hFFFF);
    tick();

    // clr mid-run: fill with FFFF, then sweep with writes being ignored
    for (int a = 0; a < DEPTH; a += 2) begin
      w0_addr = AW'(a);     w0_data = 16'hFFFF; w0_we = 1'b1;
      w1_addr = AW'(a + 1); w1_data = 16'hFFFF; w1_we = 1'b1;
      tick();
    end
    idle_writes();
    set_rd(4'd0, 4'd15);
    #2;
    check("fill_ffff", r_data, 32'hFFFF_FFFF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ready_fall", {31'b0, ready}, 32'd0);
    for (int k = 0; k < DEPTH - 1; k++) begin
      w0_addr = AW'($urandom_range(0, 15)); w0_data = 16'hFFFF; w0_we = 1'b1;
      w1_addr = AW'($urandom_range(0, 15)); w1_data = 16'hFFFF; w1_we = 1'b1;
      tick();
      check("clr_ready_low", {31'b0, ready}, 32'd0);
    end
    idle_writes();
    tick();
    check("clr_ready_high", {31'b0, ready}, 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(a));
      #2;
      check("clr_zero", r_data, 32'd0);
      tick();
    end

    // Reset mid-sweep
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, ready}, 32'd0);
    tick();
    #1;
    n_rst = 1'b1;
    sweep_wait("rst_mid");

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      set_rd(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
      w0_addr = AW'($urandom_range(0, 15));
      w0_data = DW'($urandom);
      w0_we   = ($urandom_range(0, 1) == 1);
      w1_addr = ($urandom_range(0, 3) == 0) ? w0_addr : AW'($urandom_range(0, 15));
      w1_data = DW'($urandom);
      w1_we   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) set_rd(w0_addr, w1_addr);
      clr     = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle_writes();
    clr = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
